// File: rtl/gzip_bit_packer_pkg.sv
// Shared constants, state encoding and helpers for the gzip output bit packer.
package gzip_bit_packer_pkg;

  localparam int IN_WIDTH   = 32;
  localparam int SIZE_WIDTH = 6;
  localparam int OUT_WIDTH  = 32;
  localparam int ACC_WIDTH  = 2 * OUT_WIDTH;
  localparam int CNT_WIDTH  = 7;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  // Bytes needed to hold a residue of at most OUT_WIDTH bits.
  function automatic logic [2:0] ceil_bytes(input logic [CNT_WIDTH-1:0] bits);
    logic [CNT_WIDTH-1:0] rounded;
    rounded = bits + 7'd7;
    return rounded[5:3];
  endfunction

endpackage

// File: rtl/gzip_bit_packer.sv
// Packs variable-length code fields MSB-first into 32-bit words; on the last
// field the tail is zero-padded to a byte boundary and tagged with a byte count.
module gzip_bit_packer
  import gzip_bit_packer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [SIZE_WIDTH-1:0] in_size_i,
  input  logic [IN_WIDTH-1:0]   in_data_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [OUT_WIDTH-1:0]  out_data_o,
  output logic [2:0]            out_bytes_o,
  output logic                  out_last_o,
  output logic                  size_err_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_pop;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_pop;
  state_e               state_q;
  logic                 size_err_q;

  logic                 is_run, push, pop, oversize;
  logic [CNT_WIDTH-1:0] eff, shamt;
  logic [IN_WIDTH-1:0]  field_mask, field;

  assign is_run      = (state_q == ST_RUN);
  assign out_valid_o = is_run ? (cnt_q >= 7'd32) : 1'b1;
  assign out_last_o  = !is_run && (cnt_q <= 7'd32);
  assign out_bytes_o = !out_valid_o ? 3'd0 : (out_last_o ? ceil_bytes(cnt_q) : 3'd4);
  assign out_data_o  = acc_q[ACC_WIDTH-1 -: OUT_WIDTH];
  assign size_err_o  = size_err_q;

  // A full accumulator still accepts a field when the head word leaves this cycle.
  assign in_ready_o  = is_run && ((cnt_q < 7'd32) || out_ready_i);

  assign push     = in_valid_i && in_ready_o;
  assign pop      = out_valid_o && out_ready_i;
  assign oversize = (in_size_i > 6'd32);
  assign eff      = oversize ? 7'd32 : {1'b0, in_size_i};

  // 1<<32 wraps to 0 in 32 bits, so eff=32 yields an all-ones mask.
  assign field_mask = (32'd1 << eff) - 32'd1;
  assign field      = in_data_i & field_mask;

  always_comb begin
    acc_pop = acc_q;
    cnt_pop = cnt_q;
    shamt   = '0;
    if (pop) begin
      if (out_last_o) begin
        acc_pop = '0;
        cnt_pop = '0;
      end else begin
        acc_pop = acc_q << OUT_WIDTH;
        cnt_pop = cnt_q - 7'd32;
      end
    end
    acc_d = acc_pop;
    cnt_d = cnt_pop;
    if (push) begin
      // Place the field so its top bit lands just below the current valid bits.
      shamt = 7'd64 - eff - cnt_pop;
      acc_d = acc_pop | ({32'b0, field} << shamt);
      cnt_d = cnt_pop + eff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      state_q    <= ST_RUN;
      size_err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (push && oversize) begin
        size_err_q <= 1'b1;
      end
      case (state_q)
        ST_RUN:   if (push && in_last_i) state_q <= ST_FLUSH;
        ST_FLUSH: if (pop && out_last_o) state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_gzip_bit_packer.sv
// Directed and random stimulus for gzip_bit_packer, scored against a bit-queue model.
module tb_gzip_bit_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [5:0]  in_size_i = '0;
  logic [31:0] in_data_i = '0;
  logic        in_last_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic [2:0]  out_bytes_o;
  logic        out_last_o;
  logic        size_err_o;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        last;
  } word_t;

  word_t exp_q[$];
  word_t obs_q[$];
  int    obs_cyc[$];
  bit    mbits[$];
  word_t mon_e;
  word_t mon_o;
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  bit    rand_rdy = 1'b0;

  gzip_bit_packer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_size_i   (in_size_i),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_bytes_o (out_bytes_o),
    .out_last_o  (out_last_o),
    .size_err_o  (size_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a plain bit queue. Full words leave eagerly, except that a
  // stream whose final total is exactly 32 bits ends in one 4-byte last word.
  function automatic void model_push(input logic [5:0] sz, input logic [31:0] d, input bit l);
    int    eff;
    int    r;
    word_t w;
    eff = (sz > 32) ? 32 : int'(sz);
    for (int i = eff - 1; i >= 0; i--) mbits.push_back(d[i]);
    while (mbits.size() > 32 || (mbits.size() == 32 && !l)) begin
      w.data = '0;
      for (int i = 0; i < 32; i++) w.data[31-i] = mbits.pop_front();
      w.bytes = 3'd4;
      w.last  = 1'b0;
      exp_q.push_back(w);
    end
    if (l) begin
      r = mbits.size();
      w.data = '0;
      for (int i = 0; i < r; i++) w.data[31-i] = mbits.pop_front();
      w.bytes = 3'((r + 7) / 8);
      w.last  = 1'b1;
      exp_q.push_back(w);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid_o === 1'b1 && out_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("spurious_word", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", out_data_o, mon_e.data);
        chk("out_bytes", out_bytes_o, mon_e.bytes);
        chk("out_last", out_last_o, mon_e.last);
        mon_o.data  = out_data_o;
        mon_o.bytes = out_bytes_o;
        mon_o.last  = out_last_o;
        obs_q.push_back(mon_o);
        obs_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [5:0] sz, input logic [31:0] d, input bit l, output int waited);
    waited     = 0;
    in_valid_i = 1'b1;
    in_size_i  = sz;
    in_data_i  = d;
    in_last_i  = l;
    forever begin
      @(negedge clk);
      if (in_ready_o) break;
      waited++;
      if (waited > 300) break;
      tick();
    end
    if (waited > 300) chk("send_timeout", waited, 0);
    else model_push(sz, d, l);
    tick();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid_o) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_out_bytes", out_bytes_o, 0);
    chk("rst_out_last", out_last_o, 0);
    chk("rst_size_err", size_err_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready_i = 1'b1;

    // 7+9+16 bits, then last: exactly 32 bits so a single full last word.
    obs_q.delete();
    send(6'd7, 32'h55, 1'b0, w);
    send(6'd9, 32'h1FF, 1'b0, w);
    send(6'd16, 32'hABCD, 1'b1, w);
    drain();
    chk("t1_words", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      chk("t1_data", obs_q[0].data, 32'hABFFABCD);
      chk("t1_bytes", obs_q[0].bytes, 4);
      chk("t1_last", obs_q[0].last, 1);
    end

    // Eight full-width fields back to back, then an empty last field.
    obs_q.delete();
    obs_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      send(6'd32, 32'(i), 1'b0, w);
      chk("t2_no_stall", w, 0);
    end
    send(6'd0, 32'hFFFF_FFFF, 1'b1, w);
    drain();
    chk("t2_words", obs_q.size(), 9);
    if (obs_q.size() == 9) begin
      for (int i = 1; i < 8; i++) chk("t2_gap", obs_cyc[i] - obs_cyc[i-1], 1);
      chk("t2_word7", obs_q[7].data, 32'h7);
      chk("t2_empty_bytes", obs_q[8].bytes, 0);
      chk("t2_empty_last", obs_q[8].last, 1);
    end

    // Reset with 20 bits buffered: nothing emitted, next stream starts clean.
    send(6'd20, 32'hFFFFF, 1'b0, w);
    rst = 1'b1;
    mbits.delete();
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid_o, 0);
    chk("mid_rst_in_ready", in_ready_o, 1);
    chk("mid_rst_out_data", out_data_o, 0);
    tick();
    rst = 1'b0;
    obs_q.delete();
    send(6'd5, 32'h1B, 1'b1, w);
    drain();
    chk("t3_words", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      chk("t3_data", obs_q[0].data, 32'hD8000000);
      chk("t3_bytes", obs_q[0].bytes, 1);
      chk("t3_last", obs_q[0].last, 1);
    end

    // Backpressure with 48 bits buffered.
    out_ready_i = 1'b0;
    send(6'd24, 32'hA5C3E1, 1'b0, w);
    send(6'd24, 32'h1E3C5A, 1'b0, w);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready_o, 0);
      chk("bp_out_valid", out_valid_o, 1);
      if (exp_q.size() != 0) chk("bp_out_data", out_data_o, exp_q[0].data);
      tick();
    end
    out_ready_i = 1'b1;
    send(6'd16, 32'h9876, 1'b1, w);
    drain();

    // Oversize field clamps to 32 bits and flags a sticky error.
    obs_q.delete();
    send(6'd40, 32'hFFFF_FFFF, 1'b1, w);
    drain();
    chk("t4_size_err", size_err_o, 1);
    if (obs_q.size() == 1) chk("t4_data", obs_q[0].data, 32'hFFFF_FFFF);
    else chk("t4_words", obs_q.size(), 1);
    send(6'd8, 32'h12, 1'b1, w);
    drain();
    chk("t4_size_err_sticky", size_err_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_size_err_cleared", size_err_o, 0);
    tick();

    // Random fields and random consumer readiness.
    rand_rdy = 1'b1;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 120; i++) begin
        send(6'($urandom_range(0, 32)), $urandom, 1'b0, w);
      end
      send(6'($urandom_range(0, 32)), $urandom, 1'b1, w);
      drain();
    end
    rand_rdy = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
